// File: rtl/drink_pkg.sv
// Shared definitions for the drink machine: controller state encoding and the
// change/coin enumeration also used by the payment FSM.
//   state_t : IDLE=0, DRINK=1, CHANGE=2, GAP=3, FAULT=4 (3-bit)
//   coin_t  : change owed with an order (none / one half-unit coin)
package drink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRINK  = 3'd1,
    ST_CHANGE = 3'd2,
    ST_GAP    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // Change is always paid as a single half-unit coin.
  typedef enum logic {
    COIN_NONE = 1'b0,
    COIN_HALF = 1'b1
  } coin_t;

endpackage

// File: rtl/drink_order_fifo.sv
// Pending-order queue: 1-bit FIFO of change flags with wrap-around pointers.
// Ports:
//   clk, reset       : clock, async active-high reset (empties the queue)
//   i_push, i_data   : write request and change flag
//   i_pop            : read request (advances head)
//   o_head           : change flag at the head of the queue
//   o_full, o_empty  : occupancy flags
//   o_count          : number of stored orders
// A push into a full queue is accepted only when a pop happens on the same edge.
module drink_order_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_data,
  input  logic                     i_pop,
  output logic                     o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/drink_dispense_ctrl.sv
// Delivery-side controller of the drink machine. Queues vend orders from the
// payment FSM, runs the req/ack handshake with the dispenser, then drives the
// half-coin ejector when change is owed.
// Ports:
//   clk, reset   : clock, async active-high reset (aborts and flushes queue)
//   vend, change : purchase-complete pulse and its change-owed qualifier
//   drink_req    : dispenser request (whole DRINK state)
//   drink_ack    : dispenser done, only looked at in DRINK
//   coin_eject   : half-coin ejector drive, PULSE_LEN cycles
//   done         : 1-cycle pulse, order fully serviced
//   busy         : controller active or orders pending
//   overflow     : 1-cycle pulse, a vend was dropped
//   fault        : sticky dispenser timeout
//   pending      : queue occupancy
//
// state  | meaning
// IDLE   | waiting; pops the head order when the queue is non-empty
// DRINK  | drink_req high, waiting for drink_ack or timeout
// CHANGE | coin_eject high for PULSE_LEN cycles
// GAP    | done pulse; enforces one idle cycle between actuations
// FAULT  | dispenser timed out; queue frozen, left only via reset
module drink_dispense_ctrl
  import drink_pkg::*;
#(
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned PULSE_LEN   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vend,
  input  logic                      change,
  output logic                      drink_req,
  input  logic                      drink_ack,
  output logic                      coin_eject,
  output logic                      done,
  output logic                      busy,
  output logic                      overflow,
  output logic                      fault,
  output logic [$clog2(QDEPTH):0]   pending
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned PW = $clog2(PULSE_LEN + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
  localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

  state_t        r_state;
  coin_t         r_chg;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_pulse_cnt;
  logic          r_drink_req;
  logic          r_coin_eject;
  logic          r_done;
  logic          r_overflow;
  logic          r_fault;

  logic          w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;

  // A full queue still takes a vend when the head leaves on the same edge.
  assign w_pop  = (r_state == ST_IDLE) && !w_empty;
  assign w_push = vend && (r_state != ST_FAULT) && (!w_full || w_pop);

  drink_order_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (change),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_chg        <= COIN_NONE;
      r_timer      <= '0;
      r_pulse_cnt  <= '0;
      r_drink_req  <= 1'b0;
      r_coin_eject <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_overflow <= vend && !w_push;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_chg       <= coin_t'(w_head);
            r_timer     <= '0;
            r_drink_req <= 1'b1;
            r_state     <= ST_DRINK;
          end
        end
        ST_DRINK: begin
          // Ack on the timeout edge still counts as a good dispense.
          if (drink_ack) begin
            r_drink_req <= 1'b0;
            if (r_chg == COIN_HALF) begin
              r_coin_eject <= 1'b1;
              r_pulse_cnt  <= '0;
              r_state      <= ST_CHANGE;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_GAP;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_drink_req <= 1'b0;
            r_fault     <= 1'b1;
            r_state     <= ST_FAULT;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        ST_CHANGE: begin
          if (r_pulse_cnt == PULSE_LAST) begin
            r_coin_eject <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_GAP;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + PULSE_ONE;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_drink_req  <= 1'b0;
          r_coin_eject <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign drink_req  = r_drink_req;
  assign coin_eject = r_coin_eject;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign fault      = r_fault;
  assign busy       = (r_state != ST_IDLE) || (pending != '0);

endmodule

// File: tb/tb_drink_dispense_ctrl.sv
// Directed bench for drink_dispense_ctrl with default parameters
// (QDEPTH=4, TIMEOUT_CYC=16, PULSE_LEN=2). Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point.
module tb_drink_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vend = 1'b0;
  logic       change = 1'b0;
  logic       drink_ack = 1'b0;
  logic       drink_req;
  logic       coin_eject;
  logic       done;
  logic       busy;
  logic       overflow;
  logic       fault;
  logic [2:0] pending;

  int n_checks = 0;
  int n_fails  = 0;
  int n_req    = 0;
  int n_ej     = 0;
  int n_done   = 0;
  int n_ovf    = 0;

  drink_dispense_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .vend       (vend),
    .change     (change),
    .drink_req  (drink_req),
    .drink_ack  (drink_ack),
    .coin_eject (coin_eject),
    .done       (done),
    .busy       (busy),
    .overflow   (overflow),
    .fault      (fault),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkp(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_req = 0; n_ej = 0; n_done = 0; n_ovf = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (drink_req)  n_req++;
    if (coin_eject) n_ej++;
    if (done)       n_done++;
    if (overflow)   n_ovf++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!drink_req && n < 20) begin
      step();
      n++;
    end
    check1(tag, drink_req, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check1(tag, done, 1'b1);
  endtask

  logic [5:0] burst_chg;
  logic [4:0] serve_chg;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_chg = 6'b010101;   // bit i = change of vend i: 1,0,1,0,1,0
    serve_chg = 5'b10101;    // accepted orders 0..4

    // Reset state
    #2;
    check1("rst_req", drink_req, 1'b0);
    check1("rst_eject", coin_eject, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_fault", fault, 1'b0);
    checkp("rst_pending", pending, 3'd0);
    do_reset();

    // Ack outside DRINK does nothing
    drink_ack = 1'b1;
    step();
    step();
    drink_ack = 1'b0;
    check1("ack_idle_req", drink_req, 1'b0);
    check1("ack_idle_busy", busy, 1'b0);

    // Single order without change, ack 3 cycles after req
    clr_counts();
    vend = 1'b1; change = 1'b0;
    step();                               // edge 1
    vend = 1'b0;
    checkp("t1_pend_e1", pending, 3'd1);
    check1("t1_req_e1", drink_req, 1'b0);
    step();                               // edge 2
    check1("t1_req_e2", drink_req, 1'b1);
    checkp("t1_pend_e2", pending, 3'd0);
    step();
    step();                               // edge 4
    check1("t1_req_e4", drink_req, 1'b1);
    drink_ack = 1'b1;
    step();                               // edge 5
    drink_ack = 1'b0;
    check1("t1_req_e5", drink_req, 1'b0);
    check1("t1_done_e5", done, 1'b1);
    step();
    check1("t1_done_e6", done, 1'b0);
    check1("t1_busy_e6", busy, 1'b0);
    checki("t1_req_cycles", n_req, 3);
    checki("t1_eject_cycles", n_ej, 0);

    // Order with change, ack 1 cycle after req
    clr_counts();
    vend = 1'b1; change = 1'b1;
    step();
    vend = 1'b0; change = 1'b0;
    step();
    check1("t2_req", drink_req, 1'b1);
    drink_ack = 1'b1;
    step();
    drink_ack = 1'b0;
    check1("t2_eject_a", coin_eject, 1'b1);
    check1("t2_done_a", done, 1'b0);
    step();
    check1("t2_eject_b", coin_eject, 1'b1);
    step();
    check1("t2_eject_c", coin_eject, 1'b0);
    check1("t2_done_c", done, 1'b1);
    step();
    check1("t2_busy", busy, 1'b0);
    checki("t2_eject_cycles", n_ej, 2);
    checki("t2_done_count", n_done, 1);

    // Burst of 6 vends with the dispenser stalled
    clr_counts();
    for (int i = 0; i < 6; i++) begin
      vend = 1'b1; change = burst_chg[i];
      step();
    end
    vend = 1'b0; change = 1'b0;
    checkp("t3_pend_peak", pending, 3'd4);
    check1("t3_ovf_last", overflow, 1'b1);
    checki("t3_ovf_count", n_ovf, 1);
    for (int k = 0; k < 5; k++) begin
      wait_req("t3_wait_req");
      drink_ack = 1'b1;
      step();
      drink_ack = 1'b0;
      check1("t3_order_change", coin_eject, serve_chg[k]);
      wait_done("t3_wait_done");
      step();
    end
    check1("t3_busy_end", busy, 1'b0);
    checkp("t3_pend_end", pending, 3'd0);
    checki("t3_eject_cycles", n_ej, 6);
    checki("t3_done_count", n_done, 5);

    // Timeout: two orders, no ack
    clr_counts();
    vend = 1'b1; change = 1'b0;
    step();
    change = 1'b1;
    step();
    vend = 1'b0; change = 1'b0;
    repeat (20) step();
    checki("t4_req_cycles", n_req, 16);
    check1("t4_fault", fault, 1'b1);
    check1("t4_req_off", drink_req, 1'b0);
    checkp("t4_pend_frozen", pending, 3'd1);
    vend = 1'b1;
    step();
    vend = 1'b0;
    check1("t4_ovf", overflow, 1'b1);
    checkp("t4_pend_after_vend", pending, 3'd1);
    step();
    check1("t4_fault_sticky", fault, 1'b1);
    check1("t4_busy", busy, 1'b1);
    do_reset();
    check1("t4_fault_cleared", fault, 1'b0);
    checkp("t4_pend_cleared", pending, 3'd0);

    // Ack on the 16th edge of DRINK beats the timeout
    clr_counts();
    vend = 1'b1; change = 1'b0;
    step();
    vend = 1'b0;
    step();
    repeat (15) step();
    check1("t4b_req_held", drink_req, 1'b1);
    drink_ack = 1'b1;
    step();
    drink_ack = 1'b0;
    check1("t4b_no_fault", fault, 1'b0);
    check1("t4b_done", done, 1'b1);
    checki("t4b_req_cycles", n_req, 16);
    step();
    check1("t4b_busy", busy, 1'b0);

    // Reset during CHANGE with 2 orders queued
    vend = 1'b1; change = 1'b1;
    step();
    change = 1'b0;
    step();
    step();
    vend = 1'b0;
    checkp("t5_pend_2", pending, 3'd2);
    drink_ack = 1'b1;
    step();
    drink_ack = 1'b0;
    check1("t5_in_change", coin_eject, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check1("t5_async_eject", coin_eject, 1'b0);
    check1("t5_async_busy", busy, 1'b0);
    checkp("t5_async_pend", pending, 3'd0);
    step();
    reset = 1'b0;
    step();
    step();
    check1("t5_idle_busy", busy, 1'b0);
    check1("t5_idle_req", drink_req, 1'b0);
    checkp("t5_idle_pend", pending, 3'd0);

    // Full queue in IDLE, vend on the pop edge
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      vend = 1'b1; change = 1'b0;
      step();
    end
    vend = 1'b0;
    checkp("t6_pend_full", pending, 3'd4);
    drink_ack = 1'b1;
    step();
    drink_ack = 1'b0;
    check1("t6_done", done, 1'b1);
    step();
    check1("t6_idle_req", drink_req, 1'b0);
    checkp("t6_idle_pend", pending, 3'd4);
    vend = 1'b1;
    step();
    vend = 1'b0;
    checkp("t6_pend_pushpop", pending, 3'd4);
    check1("t6_no_ovf", overflow, 1'b0);
    check1("t6_req", drink_req, 1'b1);
    checki("t6_ovf_count", n_ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
